// File: rtl/ship_motion_ctrl_pkg.sv
// Shared encodings, playfield geometry and helpers for the ship motion controller.
package ship_ctrl_pkg;

  typedef enum logic [1:0] {
    GS_IDLE    = 2'b00,
    GS_OPENING = 2'b01,
    GS_RUNNING = 2'b10,
    GS_OVER    = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_EXITED
  } ship_state_e;

  localparam logic [10:0] X_START   = 11'd650;
  localparam logic [10:0] Y_START   = 11'd750;
  localparam logic [10:0] X_MIN     = 11'd50;
  localparam logic [10:0] X_MAX     = 11'd1330;
  localparam logic [10:0] Y_MIN     = 11'd10;
  localparam logic [10:0] Y_MAX     = 11'd750;
  localparam logic [10:0] SHIP_HALF = 11'd16;

  // Top speed is one step per tick plus one per closed switch.
  function automatic logic [2:0] max_speed(input logic [2:0] sw);
    return 3'd1 + {2'b00, sw[0]} + {2'b00, sw[1]} + {2'b00, sw[2]};
  endfunction

endpackage

// File: rtl/ship_motion_ctrl_if.sv
// Board-side inputs and position/status outputs of the ship motion controller.
interface ship_motion_ctrl_if;
  logic [1:0]  game_state;
  logic [4:0]  btn;
  logic [2:0]  sw;
  logic [10:0] exit_x;
  logic [10:0] blkpos_x;
  logic [10:0] blkpos_y;
  logic        tick;
  logic        moving;
  logic        exit_entered;

  modport master (
    output game_state, btn, sw, exit_x,
    input  blkpos_x, blkpos_y, tick, moving, exit_entered
  );

  modport slave (
    input  game_state, btn, sw, exit_x,
    output blkpos_x, blkpos_y, tick, moving, exit_entered
  );
endinterface

// File: rtl/ship_motion_ctrl_debounce.sv
// Single-button debouncer: the accepted level follows the raw input only after
// it has disagreed for DEB_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (raw == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      cnt   <= '0;
      level <= raw;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ship_motion_ctrl.sv
// Player-ship sequencer: debounces direction buttons, ramps speed, and moves the
// ship on each game tick within the playfield and through the exit gap.
module ship_motion_ctrl
  import ship_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 3333333,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned RAMP_TICKS = 8,
  parameter int unsigned EXIT_WIDTH = 100
) (
  input  logic             clk,
  input  logic             rst,
  ship_motion_ctrl_if.slave bus
);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

  ship_state_e   state, state_nxt;
  game_state_e   gs;
  logic [TW-1:0] tick_cnt;
  logic          tick_q;
  logic          up, left, right, down;
  logic [10:0]   pos_x, pos_y, x_nxt, y_nxt, x_mv, y_mv;
  logic [2:0]    spd, spd_nxt, spd_up, smax;
  logic [RW-1:0] ramp, ramp_nxt;
  logic          moving_q, moving_nxt, exit_q, exit_nxt;
  logic          any_req, do_move, in_gap;
  logic [11:0]   x12, y12, s12, ship_mid, gap_lo, gap_hi, floor_y;

  assign gs = game_state_e'(bus.game_state);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
      tick_cnt <= '0;
      tick_q   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick_q   <= 1'b0;
    end
  end

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up    (.clk(clk), .rst(rst), .raw(bus.btn[1]), .level(up));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left  (.clk(clk), .rst(rst), .raw(bus.btn[2]), .level(left));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (.clk(clk), .rst(rst), .raw(bus.btn[3]), .level(right));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down  (.clk(clk), .rst(rst), .raw(bus.btn[4]), .level(down));

  assign any_req = (up ^ down) | (left ^ right);
  assign do_move = (state == S_RUN) && tick_q && (gs == GS_RUNNING);
  assign smax    = max_speed(bus.sw);

  // Candidate position; 12-bit compares keep every bound free of wrap-around.
  always_comb begin
    x12      = {1'b0, pos_x};
    y12      = {1'b0, pos_y};
    s12      = {9'b0, spd};
    ship_mid = x12 + 12'(SHIP_HALF);
    gap_lo   = {1'b0, bus.exit_x};
    gap_hi   = {1'b0, bus.exit_x} + 12'(EXIT_WIDTH);
    in_gap   = (gap_lo <= ship_mid) && (ship_mid <= gap_hi);
    floor_y  = in_gap ? 12'd0 : 12'(Y_MIN);
    x_mv     = pos_x;
    y_mv     = pos_y;
    if (left && !right)
      x_mv = (x12 >= 12'(X_MIN) + s12) ? 11'(x12 - s12) : X_MIN;
    else if (right && !left)
      x_mv = (x12 + s12 <= 12'(X_MAX)) ? 11'(x12 + s12) : X_MAX;
    if (up && !down)
      y_mv = (y12 >= floor_y + s12) ? 11'(y12 - s12) : 11'(floor_y);
    else if (down && !up)
      y_mv = (y12 + s12 <= 12'(Y_MAX)) ? 11'(y12 + s12) : Y_MAX;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_HOLD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (gs == GS_OPENING) begin
      state_nxt = S_HOLD;
    end else begin
      case (state)
        S_HOLD:   if (gs == GS_RUNNING) state_nxt = S_RUN;
        S_RUN:    if (gs != GS_RUNNING) state_nxt = S_HOLD;
                  else if (do_move && y_mv == '0) state_nxt = S_EXITED;
        S_EXITED: state_nxt = S_EXITED;
        default:  state_nxt = S_HOLD;
      endcase
    end
  end

  always_comb begin
    x_nxt      = pos_x;
    y_nxt      = pos_y;
    spd_nxt    = spd;
    ramp_nxt   = ramp;
    moving_nxt = moving_q;
    exit_nxt   = 1'b0;
    spd_up     = spd;
    if (gs == GS_OPENING) begin
      x_nxt      = X_START;
      y_nxt      = Y_START;
      spd_nxt    = 3'd1;
      ramp_nxt   = '0;
      moving_nxt = 1'b0;
    end else if (do_move) begin
      x_nxt      = x_mv;
      y_nxt      = y_mv;
      moving_nxt = (x_mv != pos_x) || (y_mv != pos_y);
      exit_nxt   = (y_mv == '0);
      if (any_req) begin
        if (ramp == RW'(RAMP_TICKS - 1)) begin
          ramp_nxt = '0;
          spd_up   = spd + 3'd1;
        end else begin
          ramp_nxt = ramp + 1'b1;
        end
        spd_nxt = (spd_up > smax) ? smax : spd_up;
      end else begin
        spd_nxt  = 3'd1;
        ramp_nxt = '0;
      end
    end else if (state != S_RUN) begin
      moving_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_x    <= X_START;
      pos_y    <= Y_START;
      spd      <= 3'd1;
      ramp     <= '0;
      moving_q <= 1'b0;
      exit_q   <= 1'b0;
    end else begin
      pos_x    <= x_nxt;
      pos_y    <= y_nxt;
      spd      <= spd_nxt;
      ramp     <= ramp_nxt;
      moving_q <= moving_nxt;
      exit_q   <= exit_nxt;
    end
  end

  assign bus.blkpos_x     = pos_x;
  assign bus.blkpos_y     = pos_y;
  assign bus.tick         = tick_q;
  assign bus.moving       = moving_q;
  assign bus.exit_entered = exit_q;

endmodule
